// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared constants and types for the writable instruction memory loader:
//   IMEM_DEPTH       - number of program bytes (16)
//   ADDR_W / DATA_W  - fetch address and byte widths
//   LAST_ADDR        - address of the final program byte in a load
//   loader_state_t   - loader FSM states (CHECK/ERROR only reachable when
//                      IMEM_LOADER_CHECKSUM_EN is defined)
//   DEFAULT_PROGRAM  - image restored into memory by reset
//   csum_update()    - running XOR checksum step
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int IMEM_DEPTH = 32'd16;
    localparam int ADDR_W     = 32'd4;
    localparam int DATA_W     = 32'd8;

    localparam logic [ADDR_W-1:0] LAST_ADDR = 4'd15;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_ERROR = 2'd3
    } loader_state_t;

    // Boot image used until the first successful pin load.
    localparam logic [DATA_W-1:0] DEFAULT_PROGRAM [IMEM_DEPTH] = '{
        8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78,
        8'h89, 8'h9A, 8'hAB, 8'hBC, 8'hCD, 8'hDE, 8'hEF, 8'h50
    };

    // One step of the program checksum: XOR of every byte written.
    function automatic logic [DATA_W-1:0] csum_update(
        input logic [DATA_W-1:0] sum,
        input logic [DATA_W-1:0] data
    );
        return sum ^ data;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the loader pins, the CPU fetch port and the status outputs.
//   load_en, data_strobe, data_in : asynchronous program-load pins
//   rd_addr / rd_data             : combinational CPU fetch port
//   cpu_hold                      : OR into the CPU reset while loading
//   load_count, load_done, chk_err: load status
// Modports: slave = the loader block, master = whoever drives pins/fetches.
// -----------------------------------------------------------------------------
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic              load_en;
    logic              data_strobe;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              cpu_hold;
    logic [4:0]        load_count;
    logic              load_done;
    logic              chk_err;

    modport slave (
        input  load_en,
        input  data_strobe,
        input  data_in,
        input  rd_addr,
        output rd_data,
        output cpu_hold,
        output load_count,
        output load_done,
        output chk_err
    );

    modport master (
        output load_en,
        output data_strobe,
        output data_in,
        output rd_addr,
        input  rd_data,
        input  cpu_hold,
        input  load_count,
        input  load_done,
        input  chk_err
    );

endinterface

// File: rtl/imem_loader_sync_rise_detect.sv
// -----------------------------------------------------------------------------
// sync_rise_detect
// Brings an asynchronous pin into the clk domain through SYNC_STAGES flops,
// then one extra delay flop to form a single-cycle rising-edge pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input pin
//   level      : synchronized level
//   rise       : one-cycle pulse when level goes 0 -> 1
// SYNC_STAGES must be 2 or 3.
// -----------------------------------------------------------------------------
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   dly_r;

    // Synchronizer chain plus the delay flop used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            dly_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
            dly_r  <= sync_r[SYNC_STAGES-1];
        end
    end

    assign level = sync_r[SYNC_STAGES-1];
    assign rise  = level & ~dly_r;

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// 16x8 flop instruction memory with a byte-wide pin loader. A rising edge on
// load_en starts a load; each rising edge on data_strobe writes data_in to the
// next address. While loading, cpu_hold keeps the CPU in reset. Fetch reads
// (rd_addr -> rd_data) are combinational and return the old byte during the
// cycle a write to the same address is pending.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (restores the default
//                program immediately)
//   bus        : imem_loader_if.slave (pins, fetch port, status)
// Parameter SYNC_STAGES (2 or 3): synchronizer depth on both async pins.
// Optional feature macro IMEM_LOADER_CHECKSUM_EN: a 17th strobed byte must
// equal the XOR of the 16 program bytes; a mismatch parks in ERROR with
// chk_err and cpu_hold high until a new load starts or reset.
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_loader_if.slave   bus
);

    logic              ld_level_s;
    logic              ld_rise_s;
    logic              stb_level_s;
    logic              stb_rise_s;
    logic              wr_en_s;

    loader_state_t     state_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [4:0]        load_count_r;
    logic              load_done_r;
    logic              cpu_hold_r;
    logic [DATA_W-1:0] mem_r [IMEM_DEPTH];
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_r;
    logic              chk_err_r;
`endif

    sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_load_en_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.load_en),
        .level (ld_level_s),
        .rise  (ld_rise_s)
    );

    sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.data_strobe),
        .level (stb_level_s),
        .rise  (stb_rise_s)
    );

    // A byte is written only in LOAD while load_en is still held; an abort
    // in the same cycle as a strobe wins and drops the byte.
    always_comb begin
        wr_en_s = 1'b0;
        if ((state_r == ST_LOAD) && ld_level_s && stb_rise_s && stb_level_s) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Program storage: default image on reset, one byte per accepted strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r <= DEFAULT_PROGRAM;
        end else if (wr_en_s) begin
            mem_r[wr_addr_r] <= bus.data_in;
        end
    end

    // Loader FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            wr_addr_r    <= 4'd0;
            load_count_r <= 5'd0;
            load_done_r  <= 1'b0;
            cpu_hold_r   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r       <= 8'h00;
            chk_err_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_RUN: begin
                    // Strobes are ignored here; only a fresh load_en edge
                    // starts a load, so a level left high cannot re-trigger.
                    if (ld_rise_s) begin
                        state_r      <= ST_LOAD;
                        wr_addr_r    <= 4'd0;
                        load_count_r <= 5'd0;
                        load_done_r  <= 1'b0;
                        cpu_hold_r   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r       <= 8'h00;
                        chk_err_r    <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (!ld_level_s) begin
                        // Abort: keep the bytes written and the partial count.
                        state_r    <= ST_RUN;
                        cpu_hold_r <= 1'b0;
                    end else if (wr_en_s) begin
                        load_count_r <= load_count_r + 5'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r       <= csum_update(csum_r, bus.data_in);
`endif
                        if (wr_addr_r == LAST_ADDR) begin
                            // Address is left at the last entry instead of
                            // wrapping; the FSM leaves LOAD on this write.
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_r     <= ST_CHECK;
`else
                            state_r     <= ST_RUN;
                            cpu_hold_r  <= 1'b0;
                            load_done_r <= 1'b1;
`endif
                        end else begin
                            wr_addr_r <= wr_addr_r + 4'd1;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (!ld_level_s) begin
                        state_r    <= ST_RUN;
                        cpu_hold_r <= 1'b0;
                    end else if (stb_rise_s) begin
                        if (bus.data_in == csum_r) begin
                            state_r     <= ST_RUN;
                            cpu_hold_r  <= 1'b0;
                            load_done_r <= 1'b1;
                        end else begin
                            state_r   <= ST_ERROR;
                            chk_err_r <= 1'b1;
                        end
                    end
                end
                ST_ERROR: begin
                    // CPU stays held; only a new load (or reset) gets out.
                    if (ld_rise_s) begin
                        state_r      <= ST_LOAD;
                        wr_addr_r    <= 4'd0;
                        load_count_r <= 5'd0;
                        load_done_r  <= 1'b0;
                        cpu_hold_r   <= 1'b1;
                        csum_r       <= 8'h00;
                        chk_err_r    <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_r    <= ST_RUN;
                    cpu_hold_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data    = mem_r[bus.rd_addr];
    assign bus.cpu_hold   = cpu_hold_r;
    assign bus.load_count = load_count_r;
    assign bus.load_done  = load_done_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.chk_err    = chk_err_r;
`else
    assign bus.chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed plus randomized bench for imem_loader. A byte-level reference
// model (expected memory image, accepted-byte count, done/hold/error flags)
// is updated as each pin transaction completes and compared against the DUT.
// Define IMEM_LOADER_CHECKSUM_EN for both RTL and bench to cover the checksum
// variant.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    imem_loader_if bus ();

    imem_loader #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent copy of the boot image.
    logic [7:0] dflt [16] = '{
        8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78,
        8'h89, 8'h9A, 8'hAB, 8'hBC, 8'hCD, 8'hDE, 8'hEF, 8'h50
    };

    // Reference model state.
    logic [7:0] m_mem [16];
    int         m_count;
    bit         m_loading;
    bit         m_checking;
    bit         m_err;
    bit         m_done;
    logic [7:0] m_csum;

    task automatic model_reset();
        for (int k = 0; k < 16; k++) m_mem[k] = dflt[k];
        m_count = 0; m_loading = 0; m_checking = 0; m_err = 0; m_done = 0; m_csum = 8'h00;
    endtask

    task automatic model_start();
        m_loading = 1; m_checking = 0; m_err = 0; m_count = 0; m_done = 0; m_csum = 8'h00;
    endtask

    task automatic model_abort();
        if (!m_err) begin
            m_loading = 0;
            m_checking = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_loading && !m_err) begin
            if (!m_checking) begin
                m_mem[m_count] = b;
                m_csum = m_csum ^ b;
                m_count++;
                if (m_count == 16) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    m_checking = 1;
`else
                    m_loading = 0;
                    m_done = 1;
`endif
                end
            end else begin
                m_checking = 0;
                if (b == m_csum) begin
                    m_loading = 0;
                    m_done = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".cpu_hold"}, {31'd0, bus.cpu_hold}, {31'd0, m_loading});
        chk({tag, ".load_count"}, {27'd0, bus.load_count}, 32'(m_count));
        chk({tag, ".load_done"}, {31'd0, bus.load_done}, {31'd0, m_done});
        chk({tag, ".chk_err"}, {31'd0, bus.chk_err}, {31'd0, m_err});
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 16; k++) begin
            bus.rd_addr = 4'(k);
            #1;
            chk($sformatf("%s.mem%0d", tag, k), {24'd0, bus.rd_data}, {24'd0, m_mem[k]});
        end
        check_status(tag);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.data_in = b;
        bus.data_strobe = 1'b1;
        cycles(4);
        bus.data_strobe = 1'b0;
        cycles(4);
        model_byte(b);
    endtask

    task automatic start_load(input bit timing);
        bus.load_en = 1'b1;
        if (timing) begin
            cycles(2);
            chk("entry.hold_early", {31'd0, bus.cpu_hold}, 32'd0);
            cycles(1);
            chk("entry.hold_on", {31'd0, bus.cpu_hold}, 32'd1);
            cycles(1);
        end else begin
            cycles(4);
        end
        model_start();
    endtask

    task automatic drop_load();
        bus.load_en = 1'b0;
        cycles(4);
        model_abort();
    endtask

    initial begin
        logic [7:0] b;
        int         n;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.load_en = 1'b0;
        bus.data_strobe = 1'b0;
        bus.data_in = 8'h00;
        bus.rd_addr = 4'd0;
        model_reset();
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        // Reset image and status.
        check_all("reset");

        // Strobe while idle: ignored.
        send_byte(8'($urandom));
        check_all("run_strobe");

        // Full load 8'h10..8'h1F, with entry timing and read-during-write on byte 0.
        start_load(1'b1);
        bus.rd_addr = 4'd0;
        bus.data_in = 8'h10;
        bus.data_strobe = 1'b1;
        cycles(2);
        chk("rdw.old", {24'd0, bus.rd_data}, {24'd0, m_mem[0]});
        chk("rdw.hold", {31'd0, bus.cpu_hold}, 32'd1);
        cycles(1);
        chk("rdw.new", {24'd0, bus.rd_data}, 32'h10);
        cycles(1);
        bus.data_strobe = 1'b0;
        cycles(4);
        model_byte(8'h10);
        for (int k = 1; k < 16; k++) begin
            send_byte(8'h10 + 8'(k));
            chk($sformatf("full.hold%0d", k), {31'd0, bus.cpu_hold}, {31'd0, m_loading});
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("full.check_hold", {31'd0, bus.cpu_hold}, 32'd1);
        send_byte(m_csum);
`endif
        check_all("full");

        // Extra strobe with load_en still high: no write, no restart.
        send_byte(8'hA5);
        check_all("post_done_strobe");

        // Abort after 5 bytes.
        drop_load();
        start_load(1'b0);
        for (int k = 0; k < 5; k++) send_byte(8'($urandom));
        drop_load();
        check_all("abort");

        // Randomized loads: full or aborted at a random byte count.
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(16, 1);
            start_load(1'b0);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                send_byte(b);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (n == 16) send_byte(m_csum);
`endif
            drop_load();
            check_all($sformatf("rand%0d", it));
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch.
        start_load(1'b0);
        for (int k = 0; k < 16; k++) send_byte(8'h01);
        send_byte(8'h00);
        check_status("csum_ok");
        drop_load();
        start_load(1'b0);
        for (int k = 0; k < 16; k++) send_byte(8'h01);
        send_byte(8'hFF);
        check_status("csum_bad");
        drop_load();
        check_status("csum_err_held");
        start_load(1'b0);
        check_status("csum_rearm");
        drop_load();
        check_all("csum_end");
`endif

        // Reset in the middle of a load.
        start_load(1'b0);
        for (int k = 0; k < 7; k++) send_byte(8'($urandom));
        bus.rd_addr = 4'd3;
        @(negedge clk);
        rst_n = 1'b0;
        bus.load_en = 1'b0;
        #1;
        model_reset();
        chk("midrst.mem3", {24'd0, bus.rd_data}, {24'd0, dflt[3]});
        chk("midrst.hold", {31'd0, bus.cpu_hold}, 32'd0);
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        check_all("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writable instruction memory with a byte-wide pin loader, the write-side counterpart to the CPU's instruction fetch. It accepts a 16-byte program from the dedicated input pins under a strobe handshake, stores it in a 16x8 flop array, and serves combinational fetch reads to the CPU. While a load is in progress it holds the CPU in reset via `cpu_hold`.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `load_en` and `data_strobe`; legal values are 2 or 3.
- `clk`, input, 1: single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `load_en`, input, 1: asynchronous pin; a rising edge starts a load, a low level aborts one.
- `data_strobe`, input, 1: asynchronous pin; each rising edge writes one byte.
- `data_in`, input, 8: program byte; must be stable while strobe is high.
- `rd_addr`, input, 4: CPU fetch address.
- `rd_data`, output, 8: `mem[rd_addr]`, combinational.
- `cpu_hold`, output, 1: high while loading; OR this into the CPU reset.
- `load_count`, output, 5: number of bytes accepted in the current or last load.
- `load_done`, output, 1: sticky; set when a load completes successfully.
- `chk_err`, output, 1: checksum mismatch (only with `IMEM_LOADER_CHECKSUM_EN`).

## Operation
- **Reset values.** The memory takes `DEFAULT_PROGRAM` (entry 0 = 8'h01, entry 15 = 8'h50). The FSM enters RUN. `cpu_hold` = 0, `load_done` = 0, `load_count` = 0, `chk_err` = 0.
- **Strobe capture.** `load_en` and `data_strobe` each pass through `SYNC_STAGES` flops plus one delay flop. A rise pulse is `sync & ~delay`.
- **FSM states:** RUN, LOAD, CHECK (macro only), ERROR (macro only).
- **RUN.**
  - `cpu_hold` = 0 and strobe pulses are ignored.
  - A `load_en` rise pulse moves the FSM to LOAD. On entry: write address = 0, `load_count` = 0, `load_done` = 0, `chk_err` = 0, checksum = 0.
- **LOAD.**
  - `cpu_hold` = 1.
  - Each strobe pulse writes `mem[addr] = data_in`, then increments `addr` and `load_count`, and XORs `data_in` into the checksum.
  - After the 16th write, with no macro: go to RUN and set `load_done`.
  - After the 16th write, with the macro: go to CHECK.
- **Abort.** Synced `load_en` low in LOAD or CHECK returns to RUN.
  - `load_done` stays 0 and bytes already written are kept.
  - `load_count` shows the partial count.
- **Address width.** `addr` is 4 bits and is never allowed to wrap within a load. The FSM leaves LOAD on the 16th write, so a 17th strobe is never written.
- **Re-arm.** A new load requires `load_en` to fall and rise again. A level that stays high after completion does not restart a load.
- **Read-during-write.** When `rd_addr` equals the write address in the write cycle, `rd_data` returns the old byte until the clock edge.
- **Reset mid-load.** Asynchronous reset restores `DEFAULT_PROGRAM` immediately and enters RUN.

## Timing
- **Strobe to write.** A strobe rise before edge N is registered into memory at edge N + `SYNC_STAGES`. With the default of 2 that is edge N+2.
- **Data hold.** `data_in` must be held from the strobe rise through that edge, i.e. for at least `SYNC_STAGES`+1 cycles.
- **Strobe pulse widths.** Strobe high time and low time are each at least `SYNC_STAGES`+1 cycles. Shorter pulses may be lost.
- **Load entry.** `cpu_hold` rises `SYNC_STAGES`+1 cycles after the `load_en` rise.
- **Load exit.** `cpu_hold` falls in the cycle after the final write (no macro) or after the check (macro).
- **CPU restart.** The CPU's first fetch after a load is from `rd_addr` 0, because of its own reset.
- **Read path.** `rd_data` has zero-cycle latency from `rd_addr`.

## Configuration
- **`IMEM_LOADER_CHECKSUM_EN` defined:**
  - CHECK waits for a 17th strobe byte and compares it with the XOR of the 16 program bytes.
  - On a match: go to RUN and set `load_done`.
  - On a mismatch: go to ERROR, with `chk_err` = 1 and `cpu_hold` = 1. ERROR exits only on a `load_en` rise (new load) or on reset.
- **`IMEM_LOADER_CHECKSUM_EN` undefined:**
  - CHECK and ERROR are absent.
  - `chk_err` is tied to 0.
  - The load completes on the 16th byte.

## Structure
- Package `imem_loader_pkg` holds:
  - the `IMEM_DEPTH = 16` constant;
  - the state enum `loader_state_t`;
  - the `DEFAULT_PROGRAM` constant array (16 x 8).
- Sub-module `sync_rise_detect`: `SYNC_STAGES` synchronizer plus a rising-edge pulse, outputs `level` and `rise`. It is instantiated twice, once for `load_en` and once for `data_strobe`.

## Test plan
- **Reset.** Assert `rst_n` = 0, then release. Required: `rd_addr` = 0 gives 8'h01, `rd_addr` = 15 gives 8'h50, `cpu_hold` = 0, `load_count` = 0.
- **Full load.** Raise `load_en`, then strobe 16 bytes 8'h10..8'h1F with legal timing. Required: `cpu_hold` high throughout, then `load_done` = 1, `load_count` = 16, `mem[k]` = 8'h10+k, and `cpu_hold` = 0.
- **Abort.** Strobe 5 bytes, then drop `load_en`. Required: RUN, `load_done` = 0, `load_count` = 5, entries 0-4 new, entries 5-15 unchanged.
- **Ignored strobes.** Strobe in RUN, and strobe after the 16th byte while `load_en` stays high. Required: memory unchanged and no new load started.
- **Checksum (macro).** Load 16 bytes of 8'h01 followed by checksum 8'h00. Required: `load_done` = 1. Repeat with checksum 8'hFF. Required: `chk_err` = 1, `cpu_hold` stays 1, and a following `load_en` rise clears ERROR.
- **Reset mid-load.** Pulse `rst_n` low after byte 7. Required: `DEFAULT_PROGRAM` restored, RUN, `cpu_hold` = 0.
